// File: rtl/io_output_bank.sv
// io_output_bank: plain write-only output ports plus a signed-decimal port with double-dabble BCD conversion.
// Optional readback mux enabled by defining IO_OUT_READBACK_EN.
module io_output_bank #(
    parameter int          DATA_W     = 32,
    parameter int          NUM_PORTS  = 4,
    parameter logic [5:0]  BASE_IDX   = 6'h20,
    parameter int          BCD_DIGITS = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [31:0]                   addr,
    input  logic [DATA_W-1:0]             datain,
    input  logic                          write_io_enable,
    output logic [NUM_PORTS*DATA_W-1:0]   out_ports,
    output logic                          sign_out,
    output logic [4*BCD_DIGITS-1:0]       bcd_out,
    output logic                          bcd_busy,
    output logic                          bcd_valid,
    output logic [DATA_W-1:0]             rdata
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam int BW = 4 * BCD_DIGITS;

    typedef enum logic {IDLE, CONV} state_t;
    state_t state, state_nx;

    logic [5:0]        off;
    logic              sig_wr, done, neg;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] mag, mag_in, shift;
    logic [BW-1:0]     scratch, adj, scratch_nx;
    logic              unused_bits;

    assign off        = addr[7:2] - BASE_IDX;
    assign sig_wr     = write_io_enable && off == 6'(NUM_PORTS);
    assign done       = state == CONV && cnt == CW'(DATA_W - 1);
    assign mag_in     = datain[DATA_W-1] ? ~datain + 1'b1 : datain;
    assign bcd_busy   = state == CONV;
    assign scratch_nx = {adj[BW-2:0], shift[DATA_W-1]};

    // add-3 correction applied to every digit before the shift
    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
        assign adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        if (sig_wr)    state_nx = CONV;
        else if (done) state_nx = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_ports <= '0;
            sign_out  <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            neg       <= 1'b0;
            mag       <= '0;
            shift     <= '0;
            scratch   <= '0;
            cnt       <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (write_io_enable && off == 6'(i)) out_ports[i*DATA_W +: DATA_W] <= datain;
            if (sig_wr) begin
                neg       <= datain[DATA_W-1];
                mag       <= mag_in;
                shift     <= mag_in;
                scratch   <= '0;
                cnt       <= '0;
                bcd_valid <= 1'b0;
            end else if (state == CONV) begin
                shift   <= {shift[DATA_W-2:0], 1'b0};
                scratch <= scratch_nx;
                cnt     <= done ? '0 : cnt + 1'b1;
                if (done) begin
                    bcd_out   <= scratch_nx;
                    sign_out  <= neg;
                    bcd_valid <= 1'b1;
                end
            end
        end
    end

`ifdef IO_OUT_READBACK_EN
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (off == 6'(i)) rdata = out_ports[i*DATA_W +: DATA_W];
        if (off == 6'(NUM_PORTS))     rdata = neg ? ~mag + 1'b1 : mag;
        if (off == 6'(NUM_PORTS + 1)) rdata = DATA_W'({bcd_valid, bcd_busy});
    end
    assign unused_bits = ^{addr[31:8], addr[1:0]};
`else
    assign rdata       = '0;
    assign unused_bits = ^{addr[31:8], addr[1:0], mag};
`endif
endmodule
